// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with HI/LO result registers.
//
// Ports:
//   clk      - system clock, rising-edge active
//   reset    - asynchronous active-low reset
//   start    - one-cycle issue strobe for mult/multu/div/divu
//   MDcal    - operation: 1 mult, 2 multu, 3 div, 4 divu, others none
//   MDWrite  - direct write: 1 HI<=A (mthi), 2 LO<=A (mtlo), others none
//   A, B     - operands (rs / rt)
//   busy     - high while an operation is in flight
//   HI, LO   - result registers
//
// The operation is accepted on the start edge and the operands are latched.
// The result is computed from the latched operands and written to HI/LO
// on the edge where the down-counter reaches zero (5 cycles for multiply,
// 10 for divide). The same edge returns the FSM to idle.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDcal,
  input  logic [1:0]  MDWrite,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;

  localparam logic [1:0] WrHi = 2'd1;
  localparam logic [1:0] WrLo = 2'd2;

  localparam logic [3:0] MulCycles = 4'd5;
  localparam logic [3:0] DivCycles = 4'd10;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Multiply datapath: sign/zero extension to 64 bits makes the truncated
  // 64-bit product the exact two's-complement or unsigned result.
  logic [63:0] a_sx, b_sx, prod_s, prod_u;

  assign a_sx   = {{32{a_q[31]}}, a_q};
  assign b_sx   = {{32{b_q[31]}}, b_q};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Divide datapath. A zero divisor is replaced by 1 so the dividers never
  // see zero; the write is suppressed anyway. Signed division works on
  // magnitudes so that 0x80000000 / -1 yields 0x80000000 with remainder 0.
  logic [31:0] b_safe;
  logic [31:0] uq, ur;
  logic [31:0] a_mag, b_mag, sq_mag, sr_mag, sq, sr;
  logic        b_zero;

  assign b_zero = (b_q == 32'd0);
  assign b_safe = b_zero ? 32'd1 : b_q;
  assign uq     = a_q / b_safe;
  assign ur     = a_q % b_safe;
  assign a_mag  = a_q[31] ? (32'd0 - a_q) : a_q;
  assign b_mag  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
  assign sq_mag = a_mag / b_mag;
  assign sr_mag = a_mag % b_mag;
  assign sq     = (a_q[31] ^ b_safe[31]) ? (32'd0 - sq_mag) : sq_mag;
  assign sr     = a_q[31] ? (32'd0 - sr_mag) : sr_mag;

  // Result selection for the completing edge.
  logic        res_we;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    res_we = 1'b0;
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OpMult: begin
        res_we = 1'b1;
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OpMultu: begin
        res_we = 1'b1;
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OpDiv: begin
        res_we = !b_zero;
        res_hi = sr;
        res_lo = sq;
      end
      OpDivu: begin
        res_we = !b_zero;
        res_hi = ur;
        res_lo = uq;
      end
      default: res_we = 1'b0;
    endcase
  end

  logic op_valid;
  logic op_is_div;

  assign op_valid  = (MDcal == OpMult) || (MDcal == OpMultu) ||
                     (MDcal == OpDiv)  || (MDcal == OpDivu);
  assign op_is_div = (MDcal == OpDiv) || (MDcal == OpDivu);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // start wins over MDWrite even when MDcal is not an operation.
          if (op_valid) begin
            a_d     = A;
            b_d     = B;
            op_d    = MDcal;
            cnt_d   = op_is_div ? DivCycles : MulCycles;
            state_d = StRun;
          end
        end else begin
          if (MDWrite == WrHi) hi_d = A;
          if (MDWrite == WrLo) lo_d = A;
        end
      end
      StRun: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StIdle;
          if (res_we) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == StRun);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases followed by random
// operations, checked against an arithmetic reference model of HI/LO.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  MDcal;
  logic [1:0]  MDWrite;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  muldiv_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .MDcal   (MDcal),
    .MDWrite (MDWrite),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .HI      (HI),
    .LO      (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operands.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = {hi, lo};
    case (op)
      3'd1: res = sa * sb;
      3'd2: res = ua * ub;
      3'd3: if (b != 32'd0) begin
        sq  = sa / sb;
        sr  = sa % sb;
        res = {sr[31:0], sq[31:0]};
      end
      3'd4: if (b != 32'd0) begin
        uq  = ua / ub;
        ur  = ua % ub;
        res = {ur[31:0], uq[31:0]};
      end
      default: res = {hi, lo};
    endcase
    return res;
  endfunction

  // Called at a negedge; returns at the negedge after completion.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit mdw_same, input bit disturb);
    logic [63:0] r;
    int          n;
    r = ref_result(op, a, b, hi_m, lo_m);
    n = (op == 3'd1 || op == 3'd2) ? 5 : 10;
    start   = 1'b1;
    MDcal   = op;
    A       = a;
    B       = b;
    MDWrite = mdw_same ? 2'd1 : 2'd0;
    @(negedge clk);
    start   = 1'b0;
    MDcal   = 3'd0;
    MDWrite = 2'd0;
    for (int i = 0; i < n; i++) begin
      check("busy_run", {31'd0, busy}, 32'd1);
      if (disturb) begin
        A     = $urandom;
        B     = $urandom;
        MDcal = 3'($urandom_range(0, 7));
        if (i == 1) begin
          MDWrite = 2'd1;
          A       = 32'h12345678;
          start   = 1'b1;
        end else begin
          MDWrite = 2'($urandom_range(0, 2));
          start   = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
    end
    start   = 1'b0;
    MDcal   = 3'd0;
    MDWrite = 2'd0;
    {hi_m, lo_m} = r;
    check("busy_done", {31'd0, busy}, 32'd0);
    check("hi_result", HI, hi_m);
    check("lo_result", LO, lo_m);
  endtask

  task automatic direct_write(input logic [1:0] sel, input logic [31:0] a);
    MDWrite = sel;
    A       = a;
    @(negedge clk);
    MDWrite = 2'd0;
    if (sel == 2'd1) hi_m = a;
    if (sel == 2'd2) lo_m = a;
    check("hi_direct", HI, hi_m);
    check("lo_direct", LO, lo_m);
  endtask

  // start with a non-operation MDcal: nothing happens, MDWrite is dropped.
  task automatic bad_start(input logic [2:0] op, input logic [1:0] sel, input logic [31:0] a);
    start   = 1'b1;
    MDcal   = op;
    MDWrite = sel;
    A       = a;
    @(negedge clk);
    start   = 1'b0;
    MDcal   = 3'd0;
    MDWrite = 2'd0;
    check("busy_bad_start", {31'd0, busy}, 32'd0);
    check("hi_bad_start", HI, hi_m);
    check("lo_bad_start", LO, lo_m);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    int          sel;

    reset   = 1'b0;
    start   = 1'b0;
    MDcal   = 3'd0;
    MDWrite = 2'd0;
    A       = 32'd0;
    B       = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    reset = 1'b1;

    run_op(3'd1, 32'hFFFFFFFE, 32'h00000003, 1'b0, 1'b0);
    run_op(3'd2, 32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0);
    run_op(3'd3, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b1);

    direct_write(2'd1, 32'h11111111);
    direct_write(2'd2, 32'h22222222);
    run_op(3'd4, 32'h00000007, 32'h00000000, 1'b0, 1'b0);

    direct_write(2'd2, 32'hCAFEBABE);
    run_op(3'd2, 32'h00001234, 32'h00005678, 1'b0, 1'b1);
    run_op(3'd1, 32'hFFFFFFF0, 32'h00000003, 1'b1, 1'b0);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    bad_start(3'd5, 2'd1, 32'hDEADBEEF);

    // Reset during the 4th busy cycle of a divide.
    start = 1'b1;
    MDcal = 3'd3;
    A     = 32'd1000;
    B     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    MDcal = 3'd0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(3'd1, 32'd3, 32'd4, 1'b0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        rop = 3'($urandom_range(1, 4));
        ra  = $urandom;
        rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        run_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (sel <= 7) begin
        direct_write(2'($urandom_range(1, 2)), $urandom);
      end else if (sel == 8) begin
        rop = 3'($urandom_range(0, 3));
        rop = (rop == 3'd0) ? 3'd0 : rop + 3'd4;
        bad_start(rop, 2'($urandom_range(0, 2)), $urandom);
      end else begin
        ra = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'hFFFFFFFF;
        rb = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h80000000;
        run_op(3'($urandom_range(1, 4)), ra, rb, 1'b0, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately, independent of clk.
REQ-003 start  input  1  issue strobe from E stage; asserted for one cycle per mult/multu/div/divu.
REQ-004 MDcal  input  3  operation: 3'd1 signed mult, 3'd2 unsigned mult, 3'd3 signed div, 3'd4 unsigned div, others none.
REQ-005 MDWrite  input  2  direct write: 2'd1 write HI (mthi), 2'd2 write LO (mtlo), others none.
REQ-006 A  input  32  operand rs (dividend / multiplicand / mthi-mtlo source).
REQ-007 B  input  32  operand rt (divisor / multiplier).
REQ-008 busy  output  1  high while an operation is in flight; drives the stall unit.
REQ-009 HI  output  32  HI register contents.
REQ-010 LO  output  32  LO register contents.

Function
REQ-011 The block SHALL have states IDLE and RUN, plus a 4-bit down-counter cnt.
REQ-012 In IDLE, start=1 with MDcal in 1..4 SHALL latch A, B and MDcal on that edge, load cnt with 5 (mult/multu) or 10 (div/divu), and enter RUN.
REQ-013 In IDLE, start=1 with any other MDcal value SHALL be ignored.
REQ-014 busy SHALL equal (state==RUN); it rises in the cycle after the start edge and stays high for exactly 5 (mult) or 10 (div) cycles.
REQ-015 In RUN, cnt SHALL decrement on every edge; on the edge where cnt goes 1->0, HI/LO SHALL take the result and the state SHALL return to IDLE, so busy falls in the same cycle in which HI/LO show the new values.
REQ-016 mult: {HI,LO} SHALL be the 64-bit two's-complement product of the latched operands.
REQ-017 multu: {HI,LO} SHALL be the 64-bit unsigned product.
REQ-018 div: LO SHALL be the quotient truncated toward zero and HI the remainder, which takes the dividend's sign.
REQ-019 divu: LO SHALL be the unsigned quotient and HI the unsigned remainder.
REQ-020 A divide with latched B==0 SHALL run the full 10 cycles and then leave HI and LO unchanged.
REQ-021 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-022 Results SHALL depend only on operands latched at start; A, B and MDcal changes during RUN have no effect.
REQ-023 In IDLE with start=0, MDWrite=1 SHALL set HI<=A and MDWrite=2 SHALL set LO<=A on that edge.
REQ-024 If start and MDWrite are both active in the same cycle, start SHALL take priority and MDWrite SHALL be discarded.
REQ-025 In RUN, start and MDWrite SHALL be ignored; the stall unit keeps them from arriving, and the block stays safe if they do.
REQ-026 HI/LO SHALL change only per REQ-015, REQ-023 or reset.

Reset
REQ-027 While reset=0: state=IDLE, cnt=0, busy=0, HI=0, LO=0, latched operands=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation, with no partial result written; after release the block SHALL be IDLE and accept start on the first edge.

Verification
REQ-029 mult A=0xFFFFFFFE, B=0x00000003 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
REQ-030 multu A=0xFFFFFFFF, B=0x00000002 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 div A=0xFFFFFFF9 (-7), B=0x00000002 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Toggling A and B during RUN does not change the result.
REQ-032 With HI=0x11111111 and LO=0x22222222, divu A=0x00000007, B=0 -> busy 10 cycles, then HI=0x11111111, LO=0x22222222 unchanged.
REQ-033 Direct writes:
- idle mtlo A=0xCAFEBABE -> LO=0xCAFEBABE next edge.
- mthi A=0x12345678 during RUN -> HI unaffected.
- start and mthi in the same cycle -> only the multiply takes effect.
REQ-034 Reset in 4th cycle of a div -> busy, HI and LO go to 0 at once; after release, mult 3x4 -> HI=0, LO=0x0000000C after 5 cycles.
